// File: rtl/matrix_slot_manager.sv
// Matrix storage table: slot allocation, commit, lookup and round-robin eviction.
// state   | meaning
// IDLE    | armed, waiting for alloc_req
// SEARCH  | scanning slots 0..NUM_SLOTS-1 for a free one
// EVICT   | scanning from replace_ptr for an unreserved slot to recycle
// RELEASE | request answered, waiting for alloc_req to drop
module matrix_slot_manager #(
  parameter int NUM_SLOTS  = 8,
  parameter int ADDR_WIDTH = 12,
  parameter int SLOT_WORDS = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_alloc_req,
  output logic                  o_alloc_valid,
  output logic [3:0]            o_alloc_slot,
  output logic [ADDR_WIDTH-1:0] o_alloc_addr,
  output logic                  o_alloc_fail,
  input  logic                  i_alloc_cancel,
  input  logic                  i_commit_req,
  input  logic [3:0]            i_commit_slot,
  input  logic [4:0]            i_commit_m,
  input  logic [4:0]            i_commit_n,
  input  logic [ADDR_WIDTH-1:0] i_commit_addr,
  output logic                  o_commit_err,
  input  logic [3:0]            i_query_slot,
  output logic                  o_query_valid,
  output logic [4:0]            o_query_m,
  output logic [4:0]            o_query_n,
  output logic [ADDR_WIDTH-1:0] o_query_addr,
  input  logic                  i_clear_all,
  output logic [4:0]            o_valid_count,
  output logic                  o_evict_pulse
);

  typedef enum logic [1:0] {S_IDLE, S_SEARCH, S_EVICT, S_RELEASE} state_t;

  localparam logic [4:0]            LP_NUM        = 5'(NUM_SLOTS);
  localparam logic [3:0]            LP_LAST       = 4'(NUM_SLOTS - 1);
  localparam logic [ADDR_WIDTH-1:0] LP_SLOT_WORDS = ADDR_WIDTH'(SLOT_WORDS);

  state_t r_state;
  state_t w_next;
  logic   r_armed;
  logic [3:0] r_idx;
  logic [3:0] r_ptr;
  logic [3:0] r_evict_cnt;

  // Table is sized for the 4-bit slot index; entries at or above NUM_SLOTS never get set.
  logic [15:0]           r_valid;
  logic [15:0]           r_reserved;
  logic [4:0]            r_m    [16];
  logic [4:0]            r_n    [16];
  logic [ADDR_WIDTH-1:0] r_addr [16];

  logic w_idx_free, w_ptr_resv, w_commit_ok, w_active;
  logic w_grant_search, w_grant_evict, w_fail, w_evict;
  logic w_commit_apply, w_commit_rej;
  logic [3:0]            w_grant_slot;
  logic [ADDR_WIDTH-1:0] w_grant_addr;

  assign w_idx_free   = !r_valid[r_idx] && !r_reserved[r_idx];
  assign w_ptr_resv   = r_reserved[r_ptr];
  assign w_commit_ok  = i_commit_req && ({1'b0, i_commit_slot} < LP_NUM) &&
                        r_reserved[i_commit_slot] &&
                        (i_commit_m != 5'd0) && (i_commit_m <= 5'd16) &&
                        (i_commit_n != 5'd0) && (i_commit_n <= 5'd16);
  assign w_grant_addr = ADDR_WIDTH'(w_grant_slot) * LP_SLOT_WORDS;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_armed <= 1'b1;
    end else begin
      r_state <= w_next;
      r_armed <= (w_next != S_RELEASE);
    end
  end

  always_comb begin
    w_next = r_state;
    if (i_clear_all) begin
      w_next = S_RELEASE;
    end else begin
      case (r_state)
        S_IDLE:    if (i_alloc_req && r_armed) w_next = S_SEARCH;
        S_SEARCH:  if (i_alloc_cancel || w_idx_free) w_next = S_RELEASE;
                   else if (r_idx == LP_LAST) w_next = S_EVICT;
        S_EVICT:   if (i_alloc_cancel || !w_ptr_resv || (r_evict_cnt == LP_LAST)) w_next = S_RELEASE;
        S_RELEASE: if (!i_alloc_req) w_next = S_IDLE;
        default:   w_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_active       = !i_clear_all && !i_alloc_cancel;
    w_grant_search = (r_state == S_SEARCH) && w_active && w_idx_free;
    w_grant_evict  = (r_state == S_EVICT) && w_active && !w_ptr_resv;
    w_fail         = (r_state == S_EVICT) && w_active && w_ptr_resv && (r_evict_cnt == LP_LAST);
    w_evict        = w_grant_evict && r_valid[r_ptr];
    w_grant_slot   = w_grant_search ? r_idx : r_ptr;
    w_commit_apply = w_commit_ok && !i_clear_all;
    w_commit_rej   = i_commit_req && !w_commit_ok && !i_clear_all;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_alloc_valid <= 1'b0;
      o_alloc_slot  <= '0;
      o_alloc_addr  <= '0;
      o_alloc_fail  <= 1'b0;
      o_commit_err  <= 1'b0;
      o_evict_pulse <= 1'b0;
      o_valid_count <= '0;
      o_query_valid <= 1'b0;
      o_query_m     <= '0;
      o_query_n     <= '0;
      o_query_addr  <= '0;
      r_idx         <= '0;
      r_ptr         <= '0;
      r_evict_cnt   <= '0;
      r_valid       <= '0;
      r_reserved    <= '0;
      for (int i = 0; i < 16; i++) begin
        r_m[i]    <= '0;
        r_n[i]    <= '0;
        r_addr[i] <= '0;
      end
    end else begin
      o_alloc_valid <= w_grant_search || w_grant_evict;
      o_alloc_fail  <= w_fail;
      o_evict_pulse <= w_evict;
      o_commit_err  <= w_commit_rej;
      if (w_grant_search || w_grant_evict) begin
        o_alloc_slot <= w_grant_slot;
        o_alloc_addr <= w_grant_addr;
      end

      if ({1'b0, i_query_slot} < LP_NUM && r_valid[i_query_slot]) begin
        o_query_valid <= 1'b1;
        o_query_m     <= r_m[i_query_slot];
        o_query_n     <= r_n[i_query_slot];
        o_query_addr  <= r_addr[i_query_slot];
      end else begin
        o_query_valid <= 1'b0;
        o_query_m     <= '0;
        o_query_n     <= '0;
        o_query_addr  <= '0;
      end

      if (r_state == S_IDLE) r_idx <= '0;
      else if (r_state == S_SEARCH && w_next == S_SEARCH) r_idx <= r_idx + 4'd1;
      if (r_state == S_SEARCH) r_evict_cnt <= '0;
      else if (r_state == S_EVICT) r_evict_cnt <= r_evict_cnt + 4'd1;

      if (i_clear_all) begin
        r_valid       <= '0;
        r_reserved    <= '0;
        r_ptr         <= '0;
        o_valid_count <= '0;
      end else begin
        if (i_alloc_cancel) r_reserved <= '0;
        if (w_grant_search || w_grant_evict) r_reserved[w_grant_slot] <= 1'b1;
        if (w_evict) r_valid[r_ptr] <= 1'b0;
        if (r_state == S_EVICT && w_active) r_ptr <= (r_ptr == LP_LAST) ? 4'd0 : r_ptr + 4'd1;
        if (w_commit_apply) begin
          r_valid[i_commit_slot]    <= 1'b1;
          r_reserved[i_commit_slot] <= 1'b0;
          r_m[i_commit_slot]        <= i_commit_m;
          r_n[i_commit_slot]        <= i_commit_n;
          r_addr[i_commit_slot]     <= i_commit_addr;
        end
        case ({w_commit_apply, w_evict})
          2'b10:   o_valid_count <= o_valid_count + 5'd1;
          2'b01:   o_valid_count <= o_valid_count - 5'd1;
          default: o_valid_count <= o_valid_count;
        endcase
      end
    end
  end

endmodule

// File: doc/matrix_slot_manager.md
Name: matrix_slot_manager

Overview:
- Owns the matrix storage table: slot allocation, commit, lookup and eviction for every matrix held in BRAM.
- Sits directly downstream of the generate and input modes. It answers their alloc_req with a slot and base address, and records each commit_req (slot, m, n, addr).
- Serves read-side modes (display, compute) through a registered query port.

Parameters:
- NUM_SLOTS, 8, number of matrix slots (1..16).
- ADDR_WIDTH, 12, BRAM word-address width.
- SLOT_WORDS, 256, words reserved per slot. Constraint: NUM_SLOTS*SLOT_WORDS <= 2^ADDR_WIDTH.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- alloc_req  in  1  allocation request; level, may stay high after grant
- alloc_valid  out  1  one-cycle grant strobe
- alloc_slot  out  4  granted slot index
- alloc_addr  out  ADDR_WIDTH  granted base address
- alloc_fail  out  1  one-cycle strobe: no slot obtainable
- alloc_cancel  in  1  pulse: release all reserved-but-uncommitted slots
- commit_req  in  1  one-cycle commit strobe
- commit_slot  in  4  slot being committed
- commit_m  in  5  rows, 1..16
- commit_n  in  5  columns, 1..16
- commit_addr  in  ADDR_WIDTH  base address of the committed data
- commit_err  out  1  one-cycle strobe: commit rejected
- query_slot  in  4  slot to look up
- query_valid  out  1  slot holds a committed matrix
- query_m  out  5  stored rows
- query_n  out  5  stored columns
- query_addr  out  ADDR_WIDTH  stored base address
- clear_all  in  1  pulse: empty the table
- valid_count  out  5  number of committed slots
- evict_pulse  out  1  one-cycle strobe: a committed slot was evicted

Behaviour:
- Reset is asynchronous, active-low on rst_n; clock is clk.
- Reset values: every output 0; all valid and reserved bits 0; replace_ptr=0; FSM in IDLE, armed=1.
- Per-slot state: valid, reserved, m[4:0], n[4:0], addr.
- Base address of slot k is k*SLOT_WORDS.
- Free slot: valid=0 and reserved=0.

Alloc FSM: IDLE, SEARCH, EVICT, RELEASE.
- IDLE: when alloc_req=1 and armed=1, set idx=0 and go to SEARCH.
- SEARCH: examine one slot per cycle.
  - If slot idx is free: set reserved[idx]; register alloc_valid=1, alloc_slot=idx, alloc_addr=idx*SLOT_WORDS; go to RELEASE.
  - Else if idx=NUM_SLOTS-1: go to EVICT.
  - Else: idx++.
- Grant latency: when the lowest free slot is k, alloc_valid is high in the (k+1)th cycle after the edge that first sampled alloc_req.
- EVICT: examine replace_ptr, one slot per cycle.
  - If the slot is reserved: advance replace_ptr modulo NUM_SLOTS.
  - Otherwise: clear valid; decrement valid_count; pulse evict_pulse; set reserved; grant it as in SEARCH; advance replace_ptr; go to RELEASE.
  - If NUM_SLOTS consecutive slots are all reserved: pulse alloc_fail and go to RELEASE.
- RELEASE: stay until alloc_req=0 for one cycle, then go to IDLE with armed=1. Exactly one grant per request even though the requester holds alloc_req high through the grant cycle.
- alloc_valid, alloc_fail and evict_pulse are never high for more than one cycle.
- alloc_slot and alloc_addr hold their last values between grants.

Commit:
- Accept when commit_slot < NUM_SLOTS, reserved[commit_slot]=1, and both m and n are in 1..16.
- On accept: valid=1, reserved=0, store m, n and commit_addr; valid_count++ on the next edge.
- Otherwise pulse commit_err the next cycle and leave the table unchanged.
- A commit in the same cycle as a SEARCH or EVICT step is applied. The FSM sees the updated table from the following cycle.

alloc_cancel:
- Clear every reserved bit; committed slots are untouched.
- If the FSM is in SEARCH or EVICT, go to RELEASE with no grant and no fail.

clear_all:
- Clears valid and reserved for all slots; replace_ptr=0; valid_count=0.
- FSM goes to RELEASE.
- Takes priority over commit_req and alloc_cancel in the same cycle.

Query:
- Registered, 1-cycle latency; reflects table state after the previous edge.
- query_slot >= NUM_SLOTS returns all zeros.
- Invalid slots return query_valid=0 and zeros in m, n and addr.

Width rules:
- idx and replace_ptr are 4 bits and wrap at NUM_SLOTS.
- valid_count never exceeds NUM_SLOTS and never underflows.

Test Plan:
- Reset, then alloc_req held high for 6 cycles → single alloc_valid with slot 0, addr 0, exactly 1 cycle after the sampling edge. No second grant until alloc_req has dropped.
- Grant slot 0, commit (slot 0, m=3, n=4, addr 0), then query slot 0 → query_valid=1, m=3, n=4, addr 0; valid_count=1. Next alloc grants slot 1, addr 256, with 2-cycle latency.
- Fill all 8 slots, then alloc → evict_pulse plus grant of slot 0 (replace_ptr 0→1); valid_count 8→7. The next full alloc evicts slot 1.
- Commit to an unreserved slot 5, and commit with m=0 → commit_err each time; table unchanged.
- Reserve 8 slots without committing, then alloc → alloc_fail pulse. Then alloc_cancel followed by alloc → slot 0 granted.
- clear_all asserted in the same cycle as a valid commit_req → table empty, valid_count=0, no commit recorded; FSM re-arms only after alloc_req low.
